// File: rtl/mips_cpu_instr_memory.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_instr_memory
// Purpose : Loadable instruction store answering CPU fetches, with fetch
//           counting, bad-fetch flagging and halt (jump-to-0) detection.
// Revision: 1.0  initial release
// ============================================================================
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter bit          BYTE_SWAP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        loaded,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        active,
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic        done
);

  localparam int unsigned       C_AW       = $clog2(DEPTH_WORDS);
  localparam logic [C_AW-1:0]   C_LAST_IDX = C_AW'(DEPTH_WORDS - 1);
  localparam logic [32:0]       C_BASE     = {1'b0, BASE_ADDR};
  localparam logic [32:0]       C_LIMIT    = C_BASE + 33'(4 * DEPTH_WORDS);

  typedef enum logic [0:0] {
    S_LOAD  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [C_AW-1:0]   r_wptr;
  logic [C_AW:0]     r_fill;
  logic              r_fault;
  logic [31:0]       r_fetch_count;
  logic              r_done;

  logic              w_xfer;
  logic              w_run;
  logic [32:0]       w_offset;
  logic [C_AW-1:0]   w_index;
  logic              w_hit;
  logic [31:0]       w_word;

  always_comb begin
    w_state_next = r_state;
    load_ready   = 1'b0;
    case (r_state)
      S_LOAD: begin
        load_ready = clk_enable;
        // The last array slot closes the load even without load_last.
        if (load_valid && clk_enable && (load_last || r_wptr == C_LAST_IDX))
          w_state_next = S_READY;
      end
      S_READY: w_state_next = S_READY;
      default: w_state_next = S_LOAD;
    endcase
  end

  assign w_xfer = load_valid && load_ready;
  assign w_run  = clk_enable && (r_state == S_READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_wptr  <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_wptr <= r_wptr + 1'b1;
        r_fill <= {1'b0, r_wptr} + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer && !reset)
      r_mem[r_wptr] <= load_data;
  end

  // Read path: 33-bit range check so addresses near the top never wrap.
  assign w_offset = {1'b0, instr_address} - C_BASE;
  assign w_index  = C_AW'(w_offset >> 2);
  assign w_hit    = ({1'b0, instr_address} >= C_BASE) &&
                    ({1'b0, instr_address} <  C_LIMIT) &&
                    (instr_address[1:0] == 2'b00) &&
                    ({1'b0, w_index} < r_fill);
  assign w_word   = w_hit ? r_mem[w_index] : 32'h0;

  generate
    if (BYTE_SWAP) begin : g_swap
      assign instr_readdata = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
    end else begin : g_pass
      assign instr_readdata = w_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
      r_done        <= 1'b0;
    end else if (w_run) begin
      if (active) begin
        if (r_fetch_count != 32'hFFFFFFFF)
          r_fetch_count <= r_fetch_count + 32'd1;
        // Address 0 is the halt target, never a fault.
        if (!w_hit && instr_address != 32'h0)
          r_fault <= 1'b1;
      end else if (instr_address == 32'h0) begin
        r_done <= 1'b1;
      end
    end
  end

  assign loaded      = (r_state == S_READY);
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_instr_memory.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_cpu_instr_memory
// Purpose : Bench for mips_cpu_instr_memory; instance 0 uses defaults,
//           instance 1 uses DEPTH_WORDS=4 and BYTE_SWAP=0.
// Revision: 1.0  initial release
// ============================================================================
module tb_mips_cpu_instr_memory;

  localparam logic [31:0] C_BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [31:0] instr_address = C_BASE;
  logic        active = 1'b0;

  logic        lready  [2];
  logic        loaded_o[2];
  logic [31:0] rdata   [2];
  logic        fault_o [2];
  logic [31:0] fcount  [2];
  logic        done_o  [2];

  int n_tests = 0;
  int n_fail  = 0;

  int          c_depth[2] = '{256, 4};
  bit          c_swap [2] = '{1'b1, 1'b0};
  logic [31:0] m_mem  [2][256];
  int          m_fill [2];
  bit          m_loaded[2];
  bit          m_fault[2];
  logic [31:0] m_count[2];
  bit          m_done [2];

  always #5 clk = ~clk;

  mips_cpu_instr_memory u_dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(lready[0]), .loaded(loaded_o[0]),
    .instr_address(instr_address), .instr_readdata(rdata[0]),
    .active(active), .fault(fault_o[0]), .fetch_count(fcount[0]), .done(done_o[0])
  );

  mips_cpu_instr_memory #(.BASE_ADDR(32'hBFC00000), .DEPTH_WORDS(4), .BYTE_SWAP(1'b0)) u_dut_small (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(lready[1]), .loaded(loaded_o[1]),
    .instr_address(instr_address), .instr_readdata(rdata[1]),
    .active(active), .fault(fault_o[1]), .fetch_count(fcount[1]), .done(done_o[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit m_hit(input int k, input logic [31:0] addr);
    longint a    = longint'(addr);
    longint base = longint'(C_BASE);
    if (a < base || a >= base + 4 * c_depth[k] || (a % 4) != 0) return 1'b0;
    return ((a - base) / 4) < m_fill[k];
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [31:0] addr);
    logic [31:0] w, r;
    if (!m_hit(k, addr)) return 32'h0;
    w = m_mem[k][(longint'(addr) - longint'(C_BASE)) / 4];
    if (!c_swap[k]) return w;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_fill[k] = 0; m_loaded[k] = 0; m_fault[k] = 0; m_count[k] = 0; m_done[k] = 0;
      end else if (clk_enable) begin
        if (m_loaded[k]) begin
          if (active) begin
            if (m_count[k] != 32'hFFFFFFFF) m_count[k] = m_count[k] + 1;
            if (!m_hit(k, instr_address) && instr_address != 0) m_fault[k] = 1;
          end else if (instr_address == 0) begin
            m_done[k] = 1;
          end
        end else if (load_valid) begin
          m_mem[k][m_fill[k]] = load_data;
          m_fill[k]++;
          if (load_last || m_fill[k] == c_depth[k]) m_loaded[k] = 1;
        end
      end
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("loaded%0d", k), 32'(loaded_o[k]), 32'(m_loaded[k]));
      check($sformatf("fault%0d", k),  32'(fault_o[k]),  32'(m_fault[k]));
      check($sformatf("count%0d", k),  fcount[k],        m_count[k]);
      check($sformatf("done%0d", k),   32'(done_o[k]),   32'(m_done[k]));
    end
  endtask

  // Inputs are set just after an edge; combinational outputs checked mid-cycle.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rdata%0d", k), rdata[k], m_read(k, instr_address));
      check($sformatf("ready%0d", k), 32'(lready[k]), 32'(!m_loaded[k] && clk_enable));
    end
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b1; active = 1'b0; load_valid = 1'b0; clk_enable = 1'b1;
    instr_address = C_BASE;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input bit last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic load_plan_prog();
    push(32'h24420008, 0); push(32'h24420002, 0);
    push(32'h00000008, 0); push(32'h24000000, 1);
  endtask

  task automatic read_at(input logic [31:0] addr, input logic [31:0] exp0, input string tag);
    instr_address = addr;
    #1;
    check(tag, rdata[0], exp0);
    step();
  endtask

  initial begin
    @(posedge clk);
    model_update();
    #1;
    check_regs();
    do_reset();
    check("rst_loaded", 32'(loaded_o[0]), 32'h0);
    check("rst_count", fcount[0], 32'h0);

    load_plan_prog();
    check("plan_loaded", 32'(loaded_o[0]), 32'h1);
    #1;
    check("plan_ready", 32'(lready[0]), 32'h0);
    read_at(C_BASE,        32'h08004224, "plan_rd0");
    read_at(C_BASE + 4,    32'h02004224, "plan_rd1");
    read_at(C_BASE + 12,   32'h00000024, "plan_rd3");
    instr_address = C_BASE;
    #1;
    check("noswap_rd0", rdata[1], 32'h24420008);
    active = 1'b1;
    read_at(C_BASE + 16, 32'h0, "beyond_fill");
    check("beyond_fault", 32'(fault_o[0]), 32'h1);

    do_reset();
    load_plan_prog();
    active = 1'b1;
    read_at(C_BASE + 2, 32'h0, "misaligned");
    check("misalign_fault", 32'(fault_o[0]), 32'h1);

    do_reset();
    load_plan_prog();
    active = 1'b1;
    read_at(32'h0, 32'h0, "halt_addr_active");
    check("halt_nofault", 32'(fault_o[0]), 32'h0);

    do_reset();
    load_plan_prog();
    instr_address = C_BASE; active = 1'b1;
    repeat (7) step();
    active = 1'b0; instr_address = 32'h0;
    step();
    check("cnt7", fcount[0], 32'd7);
    check("cnt7_done", 32'(done_o[0]), 32'h1);
    check("cnt7_fault", 32'(fault_o[0]), 32'h0);

    do_reset();
    load_plan_prog();
    instr_address = C_BASE; active = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clk_enable = (i % 2 == 1) ? 1'b0 : 1'b1;
      step();
    end
    clk_enable = 1'b1; active = 1'b0; instr_address = 32'h0;
    step();
    check("cnt_ce", fcount[0], 32'd4);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) begin
        load_valid = 1'b1;
        #1;
        check("small_full_ready", 32'(lready[1]), 32'h0);
      end
      push(32'hA0000000 + i, 0);
      if (i == 3) check("small_loaded", 32'(loaded_o[1]), 32'h1);
    end

    do_reset();
    push(32'h24420008, 0); push(32'h24420002, 0);
    do_reset();
    read_at(C_BASE, 32'h0, "reset_midload");
    push(32'h11111111, 1);
    read_at(C_BASE, 32'h11111111, "reload");

    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      clk_enable = ($urandom_range(0, 7) != 0);
      load_valid = $urandom_range(0, 1);
      load_data  = $urandom;
      load_last  = ($urandom_range(0, 9) == 0);
      active     = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       instr_address = 32'h0;
        1:       instr_address = $urandom;
        default: instr_address = C_BASE + $urandom_range(0, 4 * 258);
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
